// File: rtl/divide_sequencer.sv
// divide_sequencer: issues DIV/DIVU to a shared external divider, owns the
// architectural HI/LO registers, and stalls only HI/LO-touching operations
// while a divide is in flight.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no divide in flight; HI/LO operations are accepted
// LAUNCH | div_start asserted for one cycle, operands held
// WAIT   | waiting for div_done, bounded by TIMEOUT cycles
module divide_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_done,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err_dz,
    output logic        err_to
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_MFHI = 3'b011;
    localparam logic [2:0] OP_MFLO = 3'b100;
    localparam logic [2:0] OP_MTHI = 3'b101;
    localparam logic [2:0] OP_MTLO = 3'b110;

    // Terminal count of the WAIT timer; TIMEOUT is limited to 2..255.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] wait_count;
    logic       hilo_op;
    logic       accept;
    logic       is_div;

    // Classify the presented operation and decide whether it is taken.
    always_comb begin
        hilo_op   = op_valid && (op_code != 3'b000) && (op_code != 3'b111);
        busy      = (state != S_IDLE);
        stall     = busy && hilo_op;
        accept    = hilo_op && !busy;
        is_div    = (op_code == OP_DIV) || (op_code == OP_DIVU);
        div_start = (state == S_LAUNCH);
    end

    // Move-from read port: purely a function of op_code and HI/LO.
    always_comb begin
        rd_data = 32'd0;
        if (op_code == OP_MFHI)
            rd_data = hi;
        else if (op_code == OP_MFLO)
            rd_data = lo;
    end

    // Sequencer state, timer, latched operands, HI/LO and error pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_count   <= 8'd0;
            div_signed   <= 1'b0;
            div_dividend <= 32'd0;
            div_divisor  <= 32'd0;
            hi           <= 32'd0;
            lo           <= 32'd0;
            err_dz       <= 1'b0;
            err_to       <= 1'b0;
        end else begin
            err_dz <= 1'b0;
            err_to <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Late div_done from a flushed divide is ignored here.
                    if (accept && is_div) begin
                        if (op_b == 32'd0) begin
                            hi     <= op_a;
                            lo     <= 32'hFFFF_FFFF;
                            err_dz <= 1'b1;
                        end else begin
                            div_signed   <= (op_code == OP_DIV);
                            div_dividend <= op_a;
                            div_divisor  <= op_b;
                            state        <= S_LAUNCH;
                        end
                    end else if (accept && op_code == OP_MTHI) begin
                        hi <= op_a;
                    end else if (accept && op_code == OP_MTLO) begin
                        lo <= op_a;
                    end
                end
                S_LAUNCH: begin
                    wait_count <= 8'd0;
                    state      <= flush ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    // Flush takes priority over a result arriving the same cycle.
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (div_done) begin
                        hi    <= div_r;
                        lo    <= div_q;
                        state <= S_IDLE;
                    end else if (wait_count == WAIT_LAST) begin
                        err_to <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
